// File: rtl/pipeline_flow_controller.sv
// PC-source and pipeline-register sequencer for the 5-stage RV32 pipeline.
// One prioritised decision per cycle: freeze > EX redirect > load-use stall > ID prediction.
module pipeline_flow_controller #(
    parameter int unsigned XLEN              = 32,
    parameter int unsigned LOAD_STALL_CYCLES = 1,
    parameter int unsigned CNT_W             = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ID_stage_branch,
    input  logic             signal_to_take_branch,
    input  logic             ALU_stage_branch,
    input  logic             flush,
    input  logic             early_prediction_is_branch_taken,
    input  logic             ALU_jump,
    input  logic [XLEN-1:0]  ALU_pc_plus4,
    input  logic [XLEN-1:0]  ALU_branch_target,
    input  logic [XLEN-1:0]  ALU_jump_target,
    input  logic [4:0]       ID_rs1,
    input  logic [4:0]       ID_rs2,
    input  logic             ID_uses_rs1,
    input  logic             ID_uses_rs2,
    input  logic             EX_mem_read,
    input  logic [4:0]       EX_rd,
    input  logic             mem_busy,
    output logic [1:0]       pc_sel,
    output logic [XLEN-1:0]  redirect_target,
    output logic             pc_write_en,
    output logic             if_id_write_en,
    output logic             if_id_flush,
    output logic             id_ex_write_en,
    output logic             id_ex_flush,
    output logic             ex_mem_write_en,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic [1:0] {StRun, StLoadStall, StMemFreeze, StPendRedirect} state_e;
    typedef enum logic [2:0] {ModeFreeze, ModeRedirect, ModeStall, ModePredict, ModeNormal} mode_e;

    localparam logic [2:0] StallInit = 3'(LOAD_STALL_CYCLES - 1);

    state_e          state_q, state_d;
    mode_e           mode;
    logic [2:0]      stall_cnt_q, stall_cnt_d;
    logic [XLEN-1:0] pend_q, pend_d;
    logic [XLEN-1:0] live_target, sel_target;
    logic [CNT_W-1:0] branch_q, mispredict_q, stall_q;
    logic            ex_redirect, load_use, run_eval, count_branch;

    assign ex_redirect = ALU_jump | (ALU_stage_branch & flush);
    assign live_target = ALU_jump ? ALU_jump_target :
                         early_prediction_is_branch_taken ? ALU_pc_plus4 : ALU_branch_target;
    assign load_use = EX_mem_read && (EX_rd != 5'd0) &&
                      ((ID_uses_rs1 && (ID_rs1 == EX_rd)) || (ID_uses_rs2 && (ID_rs2 == EX_rd)));

    always_comb begin
        state_d     = state_q;
        stall_cnt_d = stall_cnt_q;
        pend_d      = pend_q;
        mode        = ModeNormal;
        sel_target  = '0;
        run_eval    = 1'b0;
        unique case (state_q)
            StRun: run_eval = 1'b1;
            StMemFreeze: begin
                if (mem_busy) mode = ModeFreeze;
                else          run_eval = 1'b1;
            end
            StLoadStall: begin
                if (mem_busy) begin
                    mode    = ModeFreeze;
                    state_d = StMemFreeze;
                end else begin
                    mode        = ModeStall;
                    stall_cnt_d = stall_cnt_q - 3'd1;
                    if (stall_cnt_q <= 3'd1) state_d = StRun;
                end
            end
            StPendRedirect: begin
                if (mem_busy) begin
                    mode = ModeFreeze;
                end else begin
                    mode       = ModeRedirect;
                    sel_target = pend_q;
                    state_d    = StRun;
                end
            end
        endcase

        if (run_eval) begin
            state_d = StRun;
            if (mem_busy) begin
                mode = ModeFreeze;
                // Park the redirect so it survives the freeze.
                if (ex_redirect) begin
                    pend_d  = live_target;
                    state_d = StPendRedirect;
                end else begin
                    state_d = StMemFreeze;
                end
            end else if (ex_redirect) begin
                mode       = ModeRedirect;
                sel_target = live_target;
            end else if (load_use) begin
                mode        = ModeStall;
                stall_cnt_d = StallInit;
                if (LOAD_STALL_CYCLES > 1) state_d = StLoadStall;
            end else if (ID_stage_branch && signal_to_take_branch) begin
                mode = ModePredict;
            end
        end
    end

    // Live EX inputs are ignored while a parked redirect is being applied.
    assign count_branch = (mode != ModeFreeze) && (state_q != StPendRedirect) &&
                          (ALU_stage_branch || ALU_jump);

    always_comb begin
        pc_sel          = 2'd0;
        redirect_target = '0;
        pc_write_en     = 1'b1;
        if_id_write_en  = 1'b1;
        if_id_flush     = 1'b0;
        id_ex_write_en  = 1'b1;
        id_ex_flush     = 1'b0;
        ex_mem_write_en = 1'b1;
        unique case (mode)
            ModeFreeze: begin
                pc_write_en     = 1'b0;
                if_id_write_en  = 1'b0;
                id_ex_write_en  = 1'b0;
                ex_mem_write_en = 1'b0;
            end
            ModeRedirect: begin
                pc_sel          = 2'd2;
                redirect_target = sel_target;
                if_id_flush     = 1'b1;
                id_ex_flush     = 1'b1;
            end
            ModeStall: begin
                pc_write_en    = 1'b0;
                if_id_write_en = 1'b0;
                id_ex_flush    = 1'b1;
            end
            ModePredict: begin
                pc_sel      = 2'd1;
                if_id_flush = 1'b1;
            end
            ModeNormal: ;
            default: ;
        endcase
        if (!reset) begin
            pc_sel          = 2'd0;
            redirect_target = '0;
            pc_write_en     = 1'b0;
            if_id_write_en  = 1'b0;
            if_id_flush     = 1'b1;
            id_ex_write_en  = 1'b0;
            id_ex_flush     = 1'b1;
            ex_mem_write_en = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StRun;
            stall_cnt_q  <= '0;
            pend_q       <= '0;
            branch_q     <= '0;
            mispredict_q <= '0;
            stall_q      <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            pend_q      <= pend_d;
            if (count_branch && (branch_q != '1)) branch_q <= branch_q + 1'b1;
            if ((mode == ModeRedirect) && (mispredict_q != '1)) mispredict_q <= mispredict_q + 1'b1;
            if (((mode == ModeFreeze) || (mode == ModeStall)) && (stall_q != '1)) begin
                stall_q <= stall_q + 1'b1;
            end
        end
    end

    assign branch_count     = branch_q;
    assign mispredict_count = mispredict_q;
    assign stall_count      = stall_q;

endmodule
